// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: active-low segment patterns for octal digits,
// the octal digit type and the receiver FSM state encoding.
package sevenseg_pkg;

  typedef logic [2:0] octal_t;

  // Active-low patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b101_1000;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StTrack    = 2'd1,
    StCaptured = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sevenseg_pat_decode.sv
// Combinational decode of one active-low segment pattern into an octal code,
// a blank flag and an error flag (code forced to 0 unless a legal digit).
module sevenseg_pat_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg_i,
  output octal_t     code_o,
  output logic       blank_o,
  output logic       err_o
);

  always_comb begin
    code_o  = 3'd0;
    blank_o = 1'b0;
    err_o   = 1'b0;
    case (seg_i)
      SEG_0:     code_o  = 3'd0;
      SEG_1:     code_o  = 3'd1;
      SEG_2:     code_o  = 3'd2;
      SEG_3:     code_o  = 3'd3;
      SEG_4:     code_o  = 3'd4;
      SEG_5:     code_o  = 3'd5;
      SEG_6:     code_o  = 3'd6;
      SEG_7:     code_o  = 3'd7;
      SEG_BLANK: blank_o = 1'b1;
      default:   err_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_rx.sv
// Receiver for a multiplexed seven-segment display bus: debounces each scanned
// digit, collects a full frame of digits and hands it out over valid/ready.
module sevenseg_scan_rx
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    out_ready,
  output logic [3*NUM_DIGITS-1:0] out_digits,
  output logic [NUM_DIGITS-1:0]   out_blank,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_valid,
  output logic                    overrun
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

  rx_state_e state_q, state_d;
  logic [7:0]            count_q, count_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic sel_legal, sample_changed, stable_hit, latch_en, capture;

  octal_t dec_code;
  logic   dec_blank, dec_err;

  logic [3*NUM_DIGITS-1:0] slot_code_q, slot_code_d;
  logic [NUM_DIGITS-1:0]   slot_blank_q, slot_blank_d;
  logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_done;

  logic [3*NUM_DIGITS-1:0] out_digits_q, out_digits_d;
  logic [NUM_DIGITS-1:0]   out_blank_q, out_blank_d;
  logic [NUM_DIGITS-1:0]   out_err_q, out_err_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;

  // A selection is only meaningful when exactly one digit driver is active.
  assign sel_legal      = ($countones(~an) == 1);
  assign sample_changed = (seg != seg_q) || (an != an_q);
  assign stable_hit     = ((count_q + 8'd1) == StableCnt);

  sevenseg_pat_decode u_pat_decode (
    .seg_i   (seg),
    .code_o  (dec_code),
    .blank_o (dec_blank),
    .err_o   (dec_err)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (sel_legal) begin
          state_d = (StableCnt == 8'd1) ? StCaptured : StTrack;
        end
      end
      StTrack: begin
        if (!sel_legal) begin
          state_d = StIdle;
        end else if (sample_changed) begin
          state_d = (StableCnt == 8'd1) ? StCaptured : StTrack;
        end else if (stable_hit) begin
          state_d = StCaptured;
        end
      end
      StCaptured: begin
        if (!sel_legal) begin
          state_d = StIdle;
        end else if (sample_changed) begin
          state_d = (StableCnt == 8'd1) ? StCaptured : StTrack;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: sample latch, stability count and the capture strobe
  always_comb begin
    latch_en = 1'b0;
    count_d  = count_q;
    case (state_q)
      StIdle: begin
        if (sel_legal) begin
          latch_en = 1'b1;
          count_d  = 8'd1;
        end else begin
          count_d = 8'd0;
        end
      end
      StTrack, StCaptured: begin
        if (!sel_legal) begin
          count_d = 8'd0;
        end else if (sample_changed) begin
          latch_en = 1'b1;
          count_d  = 8'd1;
        end else if (state_q == StTrack) begin
          count_d = count_q + 8'd1;
        end
      end
      default: count_d = 8'd0;
    endcase
    // A fresh sample landing straight in StCaptured is a new entry too.
    capture = (state_d == StCaptured) && ((state_q != StCaptured) || latch_en);
  end

  assign seg_d = latch_en ? seg : seg_q;
  assign an_d  = latch_en ? an : an_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
      seg_q   <= 7'd0;
      an_q    <= '0;
    end else begin
      count_q <= count_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  // Slot capture and frame assembly
  always_comb begin
    slot_code_d  = slot_code_q;
    slot_blank_d = slot_blank_q;
    slot_err_d   = slot_err_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (capture && !an[i]) begin
        slot_code_d[3*i +: 3] = dec_code;
        slot_blank_d[i]       = dec_blank;
        slot_err_d[i]         = dec_err;
      end
    end
    frame_done = &seen_q;
    seen_d     = frame_done ? {NUM_DIGITS{1'b0}} : seen_q;
    if (capture) begin
      seen_d = seen_d | ~an;
    end
  end

  // Output handshake: a completed frame is dropped only if the held one is not taken.
  always_comb begin
    out_digits_d = out_digits_q;
    out_blank_d  = out_blank_q;
    out_err_d    = out_err_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q;
    if (frame_done) begin
      if (!out_valid_q || out_ready) begin
        out_digits_d = slot_code_q;
        out_blank_d  = slot_blank_q;
        out_err_d    = slot_err_q;
        out_valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_code_q  <= '0;
      slot_blank_q <= '0;
      slot_err_q   <= '0;
      seen_q       <= '0;
      out_digits_q <= '0;
      out_blank_q  <= '0;
      out_err_q    <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      slot_code_q  <= slot_code_d;
      slot_blank_q <= slot_blank_d;
      slot_err_q   <= slot_err_d;
      seen_q       <= seen_d;
      out_digits_q <= out_digits_d;
      out_blank_q  <= out_blank_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_digits = out_digits_q;
  assign out_blank  = out_blank_q;
  assign out_err    = out_err_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sevenseg_scan_rx.sv
// Directed bench for sevenseg_scan_rx at NUM_DIGITS=4, STABLE_CYCLES=4.
module tb_sevenseg_scan_rx;
  import sevenseg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = SEG_BLANK;
  logic [3:0]  an = 4'b1111;
  logic        out_ready = 1'b0;
  logic [11:0] out_digits;
  logic [3:0]  out_blank;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sevenseg_scan_rx #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .an         (an),
    .out_ready  (out_ready),
    .out_digits (out_digits),
    .out_blank  (out_blank),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .overrun    (overrun)
  );

  task automatic drive_digit(input int idx, input logic [6:0] pat, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      seg     = pat;
      an      = 4'b1111;
      an[idx] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      seg = SEG_BLANK;
      an  = 4'b1111;
    end
  endtask

  task automatic send_frame(input logic [6:0] p0, input logic [6:0] p1,
                            input logic [6:0] p2, input logic [6:0] p3);
    drive_digit(0, p0, 6);
    drive_digit(1, p1, 6);
    drive_digit(2, p2, 6);
    drive_digit(3, p3, 6);
    idle(2);
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_digits !== 12'o0000) begin
      failures++; $display("FAIL reset_digits got=%o want=0000", out_digits);
    end
    checks++;
    if (out_blank !== 4'b0000 || out_err !== 4'b0000) begin
      failures++; $display("FAIL reset_flags blank=%b err=%b want=0000/0000", out_blank, out_err);
    end
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL reset_hs valid=%b overrun=%b want=0/0", out_valid, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal_capture();
    send_frame(SEG_3, SEG_5, SEG_7, SEG_0);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL normal_valid got=%b want=1", out_valid);
    end
    checks++;
    if (out_digits !== 12'o0753) begin
      failures++; $display("FAIL normal_digits got=%o want=0753", out_digits);
    end
    checks++;
    if (out_err !== 4'b0000 || out_blank !== 4'b0000) begin
      failures++; $display("FAIL normal_flags err=%b blank=%b want=0000/0000", out_err, out_blank);
    end
    accept();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL normal_accept valid=%b want=0", out_valid);
    end
  endtask

  task automatic test_glitch();
    drive_digit(1, SEG_1, 6);
    drive_digit(2, SEG_3, 6);
    drive_digit(3, SEG_5, 6);
    for (int r = 0; r < 3; r++) begin
      drive_digit(0, SEG_2, 2);
      drive_digit(0, SEG_6, 2);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL glitch_nocapture valid=%b want=0", out_valid);
    end
    drive_digit(0, SEG_2, 4);
    idle(2);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL glitch_valid got=%b want=1", out_valid);
    end
    checks++;
    if (out_digits !== 12'o5312) begin
      failures++; $display("FAIL glitch_digits got=%o want=5312", out_digits);
    end
    accept();
  endtask

  task automatic test_illegal_blank();
    send_frame(SEG_1, 7'b000_0000, SEG_BLANK, SEG_4);
    checks++;
    if (out_err !== 4'b0010) begin
      failures++; $display("FAIL illegal_err got=%b want=0010", out_err);
    end
    checks++;
    if (out_blank !== 4'b0100) begin
      failures++; $display("FAIL illegal_blank got=%b want=0100", out_blank);
    end
    checks++;
    if (out_digits[5:3] !== 3'd0 || out_digits !== 12'o4001) begin
      failures++; $display("FAIL illegal_digits got=%o want=4001", out_digits);
    end
    accept();
  endtask

  task automatic test_backpressure();
    send_frame(SEG_1, SEG_2, SEG_3, SEG_4);
    checks++;
    if (out_valid !== 1'b1 || out_digits !== 12'o4321 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL bp_first valid=%b digits=%o overrun=%b want=1/4321/0",
               out_valid, out_digits, overrun);
    end
    send_frame(SEG_5, SEG_6, SEG_7, SEG_0);
    checks++;
    if (out_digits !== 12'o4321 || out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_hold digits=%o valid=%b want=4321/1", out_digits, out_valid);
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++; $display("FAIL bp_overrun got=%b want=1", overrun);
    end
    accept();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release valid=%b want=0", out_valid);
    end
    idle(3);
    checks++;
    if (overrun !== 1'b1) begin
      failures++; $display("FAIL bp_sticky overrun=%b want=1", overrun);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(SEG_2, SEG_2, SEG_2, SEG_2);
    checks++;
    if (out_valid !== 1'b1 || out_digits !== 12'o2222) begin
      failures++; $display("FAIL b2b_first valid=%b digits=%o want=1/2222", out_valid, out_digits);
    end
    drive_digit(0, SEG_3, 6);
    drive_digit(1, SEG_4, 6);
    drive_digit(2, SEG_5, 6);
    drive_digit(3, SEG_6, 4);
    // Frame completes on the next edge; accept the held one on that same edge.
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    seg = SEG_BLANK;
    an = 4'b1111;
    checks++;
    if (out_valid !== 1'b1 || out_digits !== 12'o6543) begin
      failures++; $display("FAIL b2b_load valid=%b digits=%o want=1/6543", out_valid, out_digits);
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++; $display("FAIL b2b_overrun got=%b want=0", overrun);
    end
    idle(2);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_hold valid=%b want=1", out_valid);
    end
  endtask

  task automatic test_reset_midframe();
    drive_digit(0, SEG_7, 6);
    drive_digit(1, SEG_1, 6);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_digits !== 12'o0000 || out_blank !== 4'b0000 || out_err !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_data digits=%o blank=%b err=%b want=0", out_digits, out_blank, out_err);
    end
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL midrst_hs valid=%b overrun=%b want=0/0", out_valid, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_digit(2, SEG_3, 6);
    drive_digit(3, SEG_5, 6);
    idle(3);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_partial valid=%b want=0", out_valid);
    end
    send_frame(SEG_7, SEG_1, SEG_3, SEG_5);
    checks++;
    if (out_valid !== 1'b1 || out_digits !== 12'o5317) begin
      failures++;
      $display("FAIL midrst_recapture valid=%b digits=%o want=1/5317", out_valid, out_digits);
    end
  endtask

  initial begin
    test_reset();
    test_normal_capture();
    test_glitch();
    test_illegal_blank();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
